// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern recognizer.
// The automaton transition table is folded into constants here; nothing is stored at runtime.
package seq_detect_pkg;

  typedef enum logic {OVERLAP, NONOVERLAP} mode_t;

  function automatic int state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Longest proper border of the first k pattern bits (first bit is pattern[len-1]).
  function automatic int fail_len(input logic [15:0] pattern, input int len, input int k);
    int  best;
    bit  ok;
    best = 0;
    for (int l = 1; l < k; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pattern[len-1-i] != pattern[len-1-(k-l+i)]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic int next_state(input logic [15:0] pattern, input int len,
                                    input mode_t mode, input int k, input logic b);
    int j;
    int res;
    bit done;
    j    = k;
    res  = 0;
    done = 1'b0;
    if (j == len) j = (mode == OVERLAP) ? fail_len(pattern, len, len) : 0;
    for (int n = 0; n <= len; n++) begin
      if (!done) begin
        if (pattern[len-1-j] == b) begin
          res  = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          j = fail_len(pattern, len, j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Serial stream in, recognizer status out.
interface seq_detect_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
);
  logic                          in;
  logic                          in_valid;
  logic                          clear;
  logic [state_w(PAT_LEN)-1:0]   s;
  logic                          match;
  logic [CNT_W-1:0]              count;

  modport master (output in, in_valid, clear, input  s, match, count);
  modport slave  (input  in, in_valid, clear, output s, match, count);
endinterface

// File: rtl/seq_detect_sat_counter.sv
// Match counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         q <= '0;
    else if (clr)                      q <= '0;
    else if (inc && (q != {W{1'b1}}))  q <= q + W'(1);
  end
endmodule

// File: rtl/seq_detect.sv
// KMP-style serial pattern recognizer with saturating match count.
//   s         | meaning
//   0         | no pattern prefix matched
//   k         | last k consumed bits equal the first k pattern bits
//   PAT_LEN   | full match, match output high
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
  parameter mode_t              MODE    = OVERLAP,
  parameter int                 CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  seq_detect_if.slave bus
);
  localparam int              SW    = state_w(PAT_LEN);
  localparam logic [15:0]     PAT16 = 16'(PATTERN);
  localparam logic [SW-1:0]   FULL  = SW'(PAT_LEN);

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_nxt;
  logic [SW-1:0] nxt0 [0:PAT_LEN];
  logic [SW-1:0] nxt1 [0:PAT_LEN];
  logic          inc;

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_delta
    localparam int N0 = next_state(PAT16, PAT_LEN, MODE, k, 1'b0);
    localparam int N1 = next_state(PAT16, PAT_LEN, MODE, k, 1'b1);
    assign nxt0[k] = SW'(N0);
    assign nxt1[k] = SW'(N1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= '0;
    else       s_q <= s_nxt;
  end

  always_comb begin
    s_nxt = s_q;
    if (bus.clear) begin
      s_nxt = '0;
    end else if (bus.in_valid) begin
      for (int k = 0; k <= PAT_LEN; k++) begin
        if (s_q == SW'(k)) s_nxt = bus.in ? nxt1[k] : nxt0[k];
      end
    end
  end

  // A clear on the same edge discards the bit, so it can never count.
  assign inc       = bus.in_valid && !bus.clear && (s_nxt == FULL);
  assign bus.s     = s_q;
  assign bus.match = (s_q == FULL);

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (inc),
    .q     (bus.count)
  );
endmodule

// File: tb/tb_seq_detect.sv
// Directed scoreboard bench: stimulus pushes expected status, monitor compares after each edge.
module tb_seq_detect;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_detect_if #(.PAT_LEN(3), .CNT_W(8)) if0 ();
  seq_detect_if #(.PAT_LEN(4), .CNT_W(8)) if1 ();
  seq_detect_if #(.PAT_LEN(4), .CNT_W(8)) if2 ();
  seq_detect_if #(.PAT_LEN(3), .CNT_W(2)) if3 ();
  seq_detect_if #(.PAT_LEN(1), .CNT_W(8)) if4 ();

  seq_detect #(.PAT_LEN(3), .PATTERN(3'b110),  .MODE(OVERLAP),    .CNT_W(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .MODE(OVERLAP),    .CNT_W(8))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .MODE(NONOVERLAP), .CNT_W(8))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  seq_detect #(.PAT_LEN(3), .PATTERN(3'b110),  .MODE(OVERLAP),    .CNT_W(2))
    u3 (.clk(clk), .reset(reset), .bus(if3));
  seq_detect #(.PAT_LEN(1), .PATTERN(1'b0),    .MODE(OVERLAP),    .CNT_W(8))
    u4 (.clk(clk), .reset(reset), .bus(if4));

  typedef struct {
    int    id;
    int    s;
    bit    m;
    int    c;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  task automatic compare(input string nm, input string what, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", nm, what, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   a_s, a_c;
    bit   a_m;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.id)
          0:       begin a_s = int'(if0.s); a_m = if0.match; a_c = int'(if0.count); end
          1:       begin a_s = int'(if1.s); a_m = if1.match; a_c = int'(if1.count); end
          2:       begin a_s = int'(if2.s); a_m = if2.match; a_c = int'(if2.count); end
          3:       begin a_s = int'(if3.s); a_m = if3.match; a_c = int'(if3.count); end
          default: begin a_s = int'(if4.s); a_m = if4.match; a_c = int'(if4.count); end
        endcase
        compare(e.nm, "s",     a_s, e.s);
        compare(e.nm, "match", int'(a_m), int'(e.m));
        compare(e.nm, "count", a_c, e.c);
      end
    end
  end

  task automatic push(input int id, input int es, input bit em, input int ec, input string nm);
    exp_t e;
    e.id = id; e.s = es; e.m = em; e.c = ec; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic drive(input int id, input bit b, input bit v, input bit c);
    {if0.in, if0.in_valid, if0.clear} = 3'b000;
    {if1.in, if1.in_valid, if1.clear} = 3'b000;
    {if2.in, if2.in_valid, if2.clear} = 3'b000;
    {if3.in, if3.in_valid, if3.clear} = 3'b000;
    {if4.in, if4.in_valid, if4.clear} = 3'b000;
    case (id)
      0:       {if0.in, if0.in_valid, if0.clear} = {b, v, c};
      1:       {if1.in, if1.in_valid, if1.clear} = {b, v, c};
      2:       {if2.in, if2.in_valid, if2.clear} = {b, v, c};
      3:       {if3.in, if3.in_valid, if3.clear} = {b, v, c};
      4:       {if4.in, if4.in_valid, if4.clear} = {b, v, c};
      default: ;
    endcase
  endtask

  task automatic step(input int id, input bit b, input bit v, input bit c,
                      input int es, input bit em, input int ec, input string nm);
    @(negedge clk);
    drive(id, b, v, c);
    push(id, es, em, ec, nm);
    @(posedge clk);
  endtask

  // Feed a bit list to one DUT, checking s/match/count after each edge.
  task automatic run_seq(input int id, input bit bits[$], input int es[$], input int ec[$],
                         input int plen, input string nm);
    foreach (bits[i]) step(id, bits[i], 1'b1, 1'b0, es[i], es[i] == plen, ec[i], nm);
  endtask

  initial begin
    drive(-1, 1'b0, 1'b0, 1'b0);
    {if0.in, if0.in_valid} = 2'b01;
    #1;
    push(0, 0, 0, 0, "in_reset");
    @(negedge clk);
    reset = 1'b0;
    push(0, 0, 0, 0, "after_reset");
    @(posedge clk);

    run_seq(0, '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 0}, 3, "dflt_0101");
    step(0, 1'b0, 1'b1, 1'b1, 0, 0, 0, "clear1");
    run_seq(0, '{1, 1, 1, 0}, '{1, 2, 2, 3}, '{0, 0, 0, 1}, 3, "dflt_1110");
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, 3, 1, 1, "idle_hold");
    run_seq(0, '{1, 1}, '{1, 2}, '{1, 1}, 3, "post_match");
    step(0, 1'b0, 1'b1, 1'b1, 0, 0, 0, "clear_wins");
    run_seq(0, '{1, 1}, '{1, 2}, '{0, 0}, 3, "pre_async");

    @(negedge clk);
    drive(-1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    push(0, 0, 0, 0, "async_reset");
    -> chk_ev;
    #3;
    @(negedge clk);
    reset = 1'b0;

    run_seq(1, '{1, 0, 1, 1, 0, 1, 1}, '{1, 2, 3, 4, 2, 3, 4}, '{0, 0, 0, 1, 1, 1, 2}, 4, "ovl_1011");
    run_seq(2, '{1, 0, 1, 1, 0, 1, 1}, '{1, 2, 3, 4, 0, 1, 1}, '{0, 0, 0, 1, 1, 1, 1}, 4, "novl_1011");

    for (int r = 0; r < 6; r++) begin
      step(3, 1'b1, 1'b1, 1'b0, 1, 0, (r > 3) ? 3 : r, "sat_b1");
      step(3, 1'b1, 1'b1, 1'b0, 2, 0, (r > 3) ? 3 : r, "sat_b2");
      step(3, 1'b0, 1'b1, 1'b0, 3, 1, (r + 1 > 3) ? 3 : r + 1, "sat_b3");
    end

    run_seq(4, '{0, 1, 0, 0}, '{1, 0, 1, 1}, '{1, 1, 2, 3}, 1, "len1");

    @(negedge clk);
    drive(-1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    compare("scoreboard", "pending", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
